// File: rtl/dma_multi_engine.sv
// dma_multi_engine: multi-channel block DMA, device -> memory over the shared CPU bus.
// NUM_CH command channels are served round-robin. Each command moves `len` blocks of
// BLOCK_WORDS words, one memory write per block, using the BR/BG handshake.
// Build option: DMA_BURST_HOLD_EN -- when defined, BR stays asserted across all blocks
// of a transfer (no GAP state). When undefined, the bus is released for one cycle
// between blocks so the CPU can steal a cycle.
//
// state | meaning
// IDLE  | waiting for a pending channel; arbitrate and latch dev_ch
// REQ   | BR high, waiting for BG
// XFER  | writing the current block; advance on doneM
// GAP   | BR low for one cycle between blocks (cycle stealing)
// DONE  | waiting for the CPU to drop BG, then pulse interrupt
module dma_multi_engine #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int NUM_CH      = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 cmd_valid,
  input  logic [NUM_CH*WORD_SIZE-1:0]       cmd_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0]       cmd_len,
  output logic [NUM_CH-1:0]                 cmd_ready,
  input  logic                              BG,
  input  logic                              doneM,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0]  edata,
  output logic                              BR,
  output logic                              WRITE,
  output logic [WORD_SIZE-1:0]              addr,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0]  data,
  output logic [CH_W-1:0]                   dev_ch,
  output logic [WORD_SIZE-1:0]              offset,
  output logic [NUM_CH-1:0]                 interrupt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           r_state;
  logic [WORD_SIZE-1:0] r_base [NUM_CH];
  logic [WORD_SIZE-1:0] r_len  [NUM_CH];
  logic [NUM_CH-1:0]    r_busy;   // slot occupied (cmd_ready = ~r_busy)
  logic [NUM_CH-1:0]    r_pend;   // slot needs bus service
  logic [NUM_CH-1:0]    r_zs1;    // zero-length command, first delay stage
  logic [NUM_CH-1:0]    r_zs2;    // zero-length command, second delay stage
  logic [NUM_CH-1:0]    r_intr;
  logic [CH_W-1:0]      r_dev_ch;
  logic [CH_W-1:0]      r_rr;
  logic [WORD_SIZE-1:0] r_offset;

  logic                 w_any_pend;
  logic [CH_W-1:0]      w_pick;
  logic [WORD_SIZE:0]   w_off_nxt;
  logic                 w_more;
  logic [WORD_SIZE-1:0] w_addr;

  // Round-robin pick: first pending channel at or after the RR pointer, wrapping.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_any_pend = 1'b0;
    w_pick     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_idx = (int'(r_rr) + k) % NUM_CH;
      if (!w_any_pend && r_pend[v_idx]) begin
        w_any_pend = 1'b1;
        w_pick     = CH_W'(v_idx);
      end
    end
  end

  assign w_off_nxt = {1'b0, r_offset} + (WORD_SIZE+1)'(1);
  assign w_more    = w_off_nxt < {1'b0, r_len[r_dev_ch]};
  assign w_addr    = r_base[r_dev_ch] + WORD_SIZE'(BLOCK_WORDS) * r_offset;

  assign BR        = (r_state == S_REQ) || (r_state == S_XFER);
  assign WRITE     = BR && BG && !doneM && (r_state == S_XFER);
  assign addr      = BG ? w_addr : 'z;
  assign data      = BG ? edata  : 'z;
  assign cmd_ready = ~r_busy;
  assign dev_ch    = r_dev_ch;
  assign offset    = r_offset;
  assign interrupt = r_intr;

  // Command slots, zero-length completion pipeline and the transfer FSM.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= '0;
      r_pend   <= '0;
      r_zs1    <= '0;
      r_zs2    <= '0;
      r_intr   <= '0;
      r_dev_ch <= '0;
      r_rr     <= '0;
      r_offset <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_base[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_intr <= '0;
      r_zs1  <= '0;
      r_zs2  <= r_zs1;

      for (int i = 0; i < NUM_CH; i++) begin
        if (cmd_valid[i] && !r_busy[i]) begin
          r_base[i] <= cmd_addr[i*WORD_SIZE +: WORD_SIZE];
          r_len[i]  <= cmd_len[i*WORD_SIZE +: WORD_SIZE];
          r_busy[i] <= 1'b1;
          if (cmd_len[i*WORD_SIZE +: WORD_SIZE] == '0)
            r_zs1[i] <= 1'b1;
          else
            r_pend[i] <= 1'b1;
        end
        // zero-length commands never touch the bus; they just complete two cycles later
        if (r_zs2[i]) begin
          r_intr[i] <= 1'b1;
          r_busy[i] <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_pend) begin
            r_dev_ch <= w_pick;
            r_offset <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (BG) r_state <= S_XFER;
        end
        S_XFER: begin
          if (doneM) begin
            if (w_more) begin
              r_offset <= w_off_nxt[WORD_SIZE-1:0];
`ifdef DMA_BURST_HOLD_EN
              r_state  <= S_XFER;
`else
              r_state  <= S_GAP;
`endif
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_GAP: begin
          r_state <= S_REQ;
        end
        S_DONE: begin
          if (!BG) begin
            r_intr[r_dev_ch] <= 1'b1;
            r_pend[r_dev_ch] <= 1'b0;
            r_busy[r_dev_ch] <= 1'b0;
            r_offset         <= '0;
            if (int'(r_dev_ch) == NUM_CH - 1)
              r_rr <= '0;
            else
              r_rr <= r_dev_ch + CH_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_multi_engine.sv
// Testbench for dma_multi_engine: table of single-channel transfers plus
// hand-written arbitration, zero-length, BG-stall and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_dma_multi_engine;
  localparam int WS = 16;
  localparam int BW = 4;
  localparam int NC = 2;
  localparam int CW = 1;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     cmd_valid = '0;
  logic [NC*WS-1:0]  cmd_addr = '0;
  logic [NC*WS-1:0]  cmd_len = '0;
  wire  [NC-1:0]     cmd_ready;
  logic              bg_q = 1'b0;
  logic              stall = 1'b0;
  wire               BG = bg_q & ~stall;
  logic              doneM = 1'b0;
  wire  [BW*WS-1:0]  edata;
  wire               BR;
  wire               WRITE;
  wire  [WS-1:0]     addr;
  wire  [BW*WS-1:0]  data;
  wire  [CW-1:0]     dev_ch;
  wire  [WS-1:0]     offset;
  wire  [NC-1:0]     interrupt;

  dma_multi_engine dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ready(cmd_ready), .BG(BG), .doneM(doneM),
    .edata(edata), .BR(BR), .WRITE(WRITE), .addr(addr), .data(data),
    .dev_ch(dev_ch), .offset(offset), .interrupt(interrupt)
  );

  always #5 CLK = ~CLK;

  // device block depends on the channel and block index being served
  assign edata = {16'hA000 ^ offset, 16'hB000 ^ offset, {15'h6000, dev_ch}, 16'hD000 + offset};

  int n_tests = 0;
  int n_fail  = 0;

  // bus/memory model and monitor state
  int            wcnt = 0;
  logic          br_prev = 1'b0;
  int            irq_cnt [NC];
  int            irq_order[$];
  logic [WS-1:0] rec_addr[$];
  logic [WS-1:0] rec_off[$];
  int            rec_ch[$];
  int            data_bad = 0;
  int            gap_q[$];
  int            low_run = 0;
  bit            seen_br = 0;
  int            br_hi = 0;

  // CPU grants one cycle after BR; memory completes two cycles after WRITE rises.
  always @(negedge CLK) begin
    if (reset) begin
      doneM   = 1'b0;
      wcnt    = 0;
      bg_q    = 1'b0;
      br_prev = 1'b0;
    end else begin
      for (int c = 0; c < NC; c++)
        if (interrupt[c]) begin
          irq_cnt[c]++;
          irq_order.push_back(c);
        end
      if (BR) begin
        br_hi++;
        if (seen_br && low_run > 0) gap_q.push_back(low_run);
        low_run = 0;
        seen_br = 1;
      end else if (seen_br) begin
        low_run++;
      end
      if (interrupt != '0) begin
        seen_br = 0;
        low_run = 0;
      end
      if (doneM) begin
        doneM = 1'b0;
        wcnt  = 0;
      end else if (WRITE) begin
        wcnt++;
        if (wcnt == 2) begin
          rec_addr.push_back(addr);
          rec_off.push_back(offset);
          rec_ch.push_back(int'(dev_ch));
          if (data !== edata) data_bad++;
          doneM = 1'b1;
        end
      end
      bg_q    = br_prev;
      br_prev = BR;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    for (int c = 0; c < NC; c++) irq_cnt[c] = 0;
    irq_order.delete();
    rec_addr.delete();
    rec_off.delete();
    rec_ch.delete();
    gap_q.delete();
    data_bad = 0;
    low_run  = 0;
    seen_br  = 0;
    br_hi    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    cmd_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic issue(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] l0,
                       input logic [15:0] a1, input logic [15:0] l1);
    cmd_addr  = {a1, a0};
    cmd_len   = {l1, l0};
    cmd_valid = v;
    tick();
    cmd_valid = '0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((cmd_ready != 2'b11 || BR || BG) && n < 3000) begin
      tick();
      n++;
    end
    check({nm, "_timeout"}, 64'(n < 3000), 64'(1));
    tick();
    tick();
  endtask

  typedef struct {
    int          ch;
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
  } vec_t;

  vec_t vecs[4];

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_a[3];
    int n;

    vecs[0] = '{ch: 0, base: 16'h0017, len: 16'd3, a0: 16'h0017, a1: 16'h001B, a2: 16'h001F};
    vecs[1] = '{ch: 1, base: 16'hFFFE, len: 16'd2, a0: 16'hFFFE, a1: 16'h0002, a2: 16'h0000};
    vecs[2] = '{ch: 0, base: 16'h0100, len: 16'd1, a0: 16'h0100, a1: 16'h0000, a2: 16'h0000};
    vecs[3] = '{ch: 1, base: 16'h0040, len: 16'd3, a0: 16'h0040, a1: 16'h0044, a2: 16'h0048};

    // reset values
    do_reset();
    check("rst_BR", 64'(BR), 64'(0));
    check("rst_WRITE", 64'(WRITE), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(2'b11));
    check("rst_interrupt", 64'(interrupt), 64'(0));
    check("rst_offset", 64'(offset), 64'(0));
    check("rst_dev_ch", 64'(dev_ch), 64'(0));

    // single-channel transfers from the table
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      exp_a[0] = vecs[v].a0;
      exp_a[1] = vecs[v].a1;
      exp_a[2] = vecs[v].a2;
      if (vecs[v].ch == 0) issue(2'b01, vecs[v].base, vecs[v].len, 16'h0, 16'h0);
      else                 issue(2'b10, 16'h0, 16'h0, vecs[v].base, vecs[v].len);
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_blocks", v), 64'(rec_addr.size()), 64'(vecs[v].len));
      for (int k = 0; k < int'(vecs[v].len) && k < rec_addr.size(); k++) begin
        check($sformatf("v%0d_addr%0d", v, k), 64'(rec_addr[k]), 64'(exp_a[k]));
        check($sformatf("v%0d_off%0d", v, k), 64'(rec_off[k]), 64'(k));
        check($sformatf("v%0d_ch%0d", v, k), 64'(rec_ch[k]), 64'(vecs[v].ch));
      end
      check($sformatf("v%0d_data", v), 64'(data_bad), 64'(0));
      check($sformatf("v%0d_irq_own", v), 64'(irq_cnt[vecs[v].ch]), 64'(1));
      check($sformatf("v%0d_irq_other", v), 64'(irq_cnt[1 - vecs[v].ch]), 64'(0));
`ifdef DMA_BURST_HOLD_EN
      check($sformatf("v%0d_gaps", v), 64'(gap_q.size()), 64'(0));
`else
      check($sformatf("v%0d_gaps", v), 64'(gap_q.size()), 64'(vecs[v].len - 1));
      for (int g = 0; g < gap_q.size(); g++)
        check($sformatf("v%0d_gaplen%0d", v, g), 64'(gap_q[g]), 64'(1));
`endif
      check($sformatf("v%0d_ready", v), 64'(cmd_ready), 64'(2'b11));
    end

    // arbitration: simultaneous pair after reset -> ch0 first
    do_reset();
    issue(2'b11, 16'h0500, 16'd2, 16'h0600, 16'd1);
    wait_done("arb1");
    check("arb1_nirq", 64'(irq_order.size()), 64'(2));
    check("arb1_first", 64'(irq_order[0]), 64'(0));
    check("arb1_second", 64'(irq_order[1]), 64'(1));
    check("arb1_addr0", 64'(rec_addr[0]), 64'(16'h0500));
    check("arb1_addr1", 64'(rec_addr[1]), 64'(16'h0504));
    check("arb1_addr2", 64'(rec_addr[2]), 64'(16'h0600));
    // ch0 alone moves the pointer to ch1, so the next pair starts with ch1
    clear_mon();
    issue(2'b01, 16'h0700, 16'd1, 16'h0, 16'h0);
    wait_done("arb2");
    check("arb2_first", 64'(irq_order[0]), 64'(0));
    clear_mon();
    issue(2'b11, 16'h0800, 16'd1, 16'h0900, 16'd2);
    wait_done("arb3");
    check("arb3_first", 64'(irq_order[0]), 64'(1));
    check("arb3_second", 64'(irq_order[1]), 64'(0));
    check("arb3_addr0", 64'(rec_addr[0]), 64'(16'h0900));
    check("arb3_addr2", 64'(rec_addr[2]), 64'(16'h0800));

    // zero length on ch1: interrupt two cycles after accept, no bus request
    do_reset();
    issue(2'b10, 16'h0, 16'h0, 16'h1234, 16'd0);
    check("zl_ready_c0", 64'(cmd_ready[1]), 64'(0));
    check("zl_irq_c0", 64'(interrupt), 64'(0));
    tick();
    check("zl_ready_c1", 64'(cmd_ready[1]), 64'(0));
    check("zl_irq_c1", 64'(interrupt), 64'(0));
    tick();
    check("zl_irq_c2", 64'(interrupt), 64'(2'b10));
    check("zl_ready_c2", 64'(cmd_ready[1]), 64'(1));
    tick();
    check("zl_irq_c3", 64'(interrupt), 64'(0));
    tick();
    tick();
    check("zl_br", 64'(br_hi), 64'(0));
    check("zl_irq_cnt", 64'(irq_cnt[1]), 64'(1));

    // BG dropped mid-XFER for 3 cycles
    do_reset();
    issue(2'b01, 16'h0200, 16'd2, 16'h0, 16'h0);
    n = 0;
    while (!WRITE && n < 200) begin
      tick();
      n++;
    end
    check("stall_reach", 64'(n < 200), 64'(1));
    stall = 1'b1;
    #1;
    check("stall_write_0", 64'(WRITE), 64'(0));
    for (int s = 1; s <= 3; s++) begin
      tick();
      check($sformatf("stall_write_%0d", s), 64'(WRITE), 64'(0));
      check($sformatf("stall_off_%0d", s), 64'(offset), 64'(0));
      check($sformatf("stall_br_%0d", s), 64'(BR), 64'(1));
    end
    stall = 1'b0;
    wait_done("stall");
    check("stall_blocks", 64'(rec_addr.size()), 64'(2));
    check("stall_addr0", 64'(rec_addr[0]), 64'(16'h0200));
    check("stall_addr1", 64'(rec_addr[1]), 64'(16'h0204));
    check("stall_irq", 64'(irq_cnt[0]), 64'(1));

    // reset at offset=1 abandons the transfer silently
    do_reset();
    issue(2'b01, 16'h0300, 16'd3, 16'h0, 16'h0);
    n = 0;
    while (offset != 16'd1 && n < 300) begin
      tick();
      n++;
    end
    check("mrst_reach", 64'(n < 300), 64'(1));
    reset = 1'b1;
    tick();
    check("mrst_BR", 64'(BR), 64'(0));
    check("mrst_WRITE", 64'(WRITE), 64'(0));
    check("mrst_ready", 64'(cmd_ready), 64'(2'b11));
    check("mrst_irq", 64'(interrupt), 64'(0));
    check("mrst_offset", 64'(offset), 64'(0));
    check("mrst_dev_ch", 64'(dev_ch), 64'(0));
    reset = 1'b0;
    clear_mon();
    repeat (20) tick();
    check("mrst_no_irq", 64'(irq_cnt[0] + irq_cnt[1]), 64'(0));
    check("mrst_no_br", 64'(br_hi), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_multi_engine.md
Name: dma_multi_engine

Overview:
Parametrised successor to the single-channel block DMA. It serves NUM_CH independent command channels with round-robin arbitration and a variable transfer length in blocks. Each transfer moves BLOCK_WORDS-word blocks from the external device into memory over the shared CPU bus using the BR/BG handshake and cycle stealing. It sits between the device, the memory (write path plus doneM) and the CPU (bus grant plus per-channel completion interrupt).

Parameters:
WORD_SIZE, 16, bits per word.
BLOCK_WORDS, 4, words per block (one memory write per block).
NUM_CH, 2, number of command channels (1..8).
CH_W, 1, channel-id width, equal to clog2(NUM_CH) with a minimum of 1.

Ports:
CLK  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  NUM_CH  per-channel command strobe.
cmd_addr  in  NUM_CH*WORD_SIZE  per-channel memory base address; channel i uses slice i.
cmd_len  in  NUM_CH*WORD_SIZE  per-channel length in blocks.
cmd_ready  out  NUM_CH  channel idle and able to accept a command.
BG  in  1  bus grant from the CPU.
doneM  in  1  memory write-complete signal.
edata  in  BLOCK_WORDS*WORD_SIZE  device block for the current dev_ch/offset.
BR  out  1  bus request.
WRITE  out  1  memory write strobe.
addr  out  WORD_SIZE  memory address; high-Z when BG=0.
data  out  BLOCK_WORDS*WORD_SIZE  write data (edata passthrough); high-Z when BG=0.
dev_ch  out  CH_W  channel currently served.
offset  out  WORD_SIZE  block index within the current transfer.
interrupt  out  NUM_CH  one-cycle completion pulse per channel.

Behaviour:
- Reset values: BR=0, WRITE=0, cmd_ready=all 1, interrupt=0, offset=0, dev_ch=0, FSM=IDLE, all pending flags cleared, RR pointer=0. A reset mid-transfer abandons the transfer with no interrupt.
- Command accept: when cmd_valid[i] && cmd_ready[i], the block latches addr/len into channel i's slot, sets pending[i], and drives cmd_ready[i]=0 from the next cycle. cmd_valid on a busy channel is ignored.
- cmd_len=0: accepted, no bus request; interrupt[i] pulses 2 cycles after accept and cmd_ready[i] returns to 1 on the same cycle.
- Arbitration in IDLE: pick the lowest pending index at or after the RR pointer (wrapping), latch it into dev_ch, set offset=0, go to REQ. After the transfer completes, the RR pointer becomes dev_ch+1 mod NUM_CH.
- FSM states:
  - IDLE: waits for a pending channel.
  - REQ: BR=1; waits for BG; on BG go to XFER.
  - XFER:
    - WRITE = BR && BG && !doneM.
    - addr = base[dev_ch] + BLOCK_WORDS*offset, truncated to WORD_SIZE, wrapping modulo 2^WORD_SIZE.
    - On doneM: if offset+1 < len, then offset++, BR=0, go to GAP. Otherwise BR=0, go to DONE.
  - GAP: BR held low exactly 1 cycle so the CPU can run a cycle (cycle stealing); then REQ.
  - DONE: waits for BG=0 (CPU reclaims the bus); then interrupt[dev_ch] pulses for 1 cycle, pending is cleared, cmd_ready is set, offset=0, go to IDLE.
- BG dropped while in XFER before doneM: WRITE deasserts combinationally; state stays XFER with BR held and no offset change; the write resumes when BG returns.
- Simultaneous completion of channel i and a new cmd_valid on channel i: the new command is not accepted that cycle because cmd_ready is still 0.
- Per-channel commands are independent: channel j may be accepted while channel i transfers.

Optional Feature:
DMA_BURST_HOLD_EN: when defined, the GAP state is skipped. BR stays asserted across all blocks and offset increments on each doneM without releasing the bus (burst mode). When undefined, cycle-stealing behaviour with the 1-cycle GAP applies.

Test Plan:
- Single channel: ch0 with addr=0x17, len=3, BG tracking BR with 1-cycle latency, doneM 2 cycles after WRITE -> addr sequence 0x17, 0x1B, 0x1F; BR low for 1 cycle between blocks; interrupt[0] single pulse after BG falls; cmd_ready[0] returns to 1.
- Arbitration: ch0 (len=2) and ch1 (len=1) issued in the same cycle -> ch0 served first, then ch1; next simultaneous pair -> ch1 served first.
- Zero length: ch1 with len=0 -> BR never asserts; interrupt[1] pulses 2 cycles after accept.
- Stall/reset: BG deasserted mid-XFER for 3 cycles -> WRITE=0 and offset unchanged, then completes normally. Reset at offset=1 -> all outputs return to reset values and no interrupt fires.
- Edge cases: addr=0xFFFE with len=2 -> second address is 0x0002. With DMA_BURST_HOLD_EN defined, len=3 -> BR high continuously from first grant to DONE.
